// File: rtl/img_pkg.sv
// Shared constants, index sizing and sweep state encoding for the image stream reader.
package img_pkg;

    localparam int unsigned IMG_W      = 390;
    localparam int unsigned IMG_H      = 390;
    localparam int unsigned IMG_PIXELS = IMG_W * IMG_H;
    localparam int unsigned ROWCOL_W   = 9;

    // The index must also hold the one-past-last value reached after the final load.
    function automatic int unsigned idx_width(input int unsigned pixels);
        return (pixels < 1) ? 1 : $clog2(pixels + 1);
    endfunction

    localparam int unsigned IDX_W = idx_width(IMG_PIXELS);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/img_rc_counter.sv
// Row/column position of the next pixel to load, with end-of-line and end-of-frame flags.
module img_rc_counter #(
    parameter int unsigned IMG_W = 390,
    parameter int unsigned IMG_H = 390
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [8:0] row_o,
    output logic [8:0] col_o,
    output logic       eol_o,
    output logic       eof_o
);
    import img_pkg::*;

    localparam logic [ROWCOL_W-1:0] LAST_COL = ROWCOL_W'(IMG_W - 1);
    localparam logic [ROWCOL_W-1:0] LAST_ROW = ROWCOL_W'(IMG_H - 1);

    logic [ROWCOL_W-1:0] row_q, row_d;
    logic [ROWCOL_W-1:0] col_q, col_d;

    assign eol_o = (col_q == LAST_COL);
    assign eof_o = eol_o && (row_q == LAST_ROW);
    assign row_o = row_q;
    assign col_o = col_q;

    // Advance raster position; clear wins, and the last pixel never wraps back to (0,0).
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (inc_i && !eof_o) begin
            if (eol_o) begin
                col_d = '0;
                row_d = row_q + ROWCOL_W'(1);
            end else begin
                col_d = col_q + ROWCOL_W'(1);
            end
        end
    end

    // Position registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/image_stream_reader.sv
// Raster-order reader of the image byte memory, presenting pixels on a valid/ready stream
// with row/column/eol/eof sideband. Never writes the memory.
module image_stream_reader #(
    parameter int unsigned          IMG_W     = img_pkg::IMG_W,
    parameter int unsigned          IMG_H     = img_pkg::IMG_H,
    parameter int unsigned          ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wd,
    input  logic [31:0]       mem_rd,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [8:0]        pix_row,
    output logic [8:0]        pix_col,
    output logic              pix_eol,
    output logic              pix_eof
);
    import img_pkg::*;

    localparam int unsigned      PIXELS   = IMG_W * IMG_H;
    localparam int unsigned      PIX_IDX_W = idx_width(PIXELS);
    localparam logic [PIX_IDX_W-1:0] LAST_IDX = PIX_IDX_W'(PIXELS - 1);

    state_e               state_q, state_d;
    logic [PIX_IDX_W-1:0] idx_q, idx_d;
    logic [7:0]           pix_data_q, pix_data_d;
    logic                 pix_valid_q, pix_valid_d;
    logic [8:0]           pix_row_q, pix_row_d;
    logic [8:0]           pix_col_q, pix_col_d;
    logic                 pix_eol_q, pix_eol_d;
    logic                 pix_eof_q, pix_eof_d;

    logic       load;
    logic       handshake;
    logic       rc_clr;
    logic [8:0] rc_row;
    logic [8:0] rc_col;
    logic       rc_eol;
    logic       rc_eof;
    logic       unused_rd;

    // Output slot is free when empty or being drained this cycle.
    assign load      = (state_q == StRun) && (!pix_valid_q || pix_ready);
    assign handshake = pix_valid_q && pix_ready;

    assign busy      = (state_q == StRun) || (state_q == StDrain);
    assign done      = (state_q == StDone);
    assign mem_addr  = BASE_ADDR + ADDR_W'(idx_q);
    assign mem_we    = 1'b0;
    assign mem_wd    = '0;
    assign unused_rd = ^mem_rd[31:8];

    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign pix_row   = pix_row_q;
    assign pix_col   = pix_col_q;
    assign pix_eol   = pix_eol_q;
    assign pix_eof   = pix_eof_q;

    img_rc_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_rc_counter (
        .clk_i (CLK),
        .rst_i (RST),
        .clr_i (rc_clr),
        .inc_i (load),
        .row_o (rc_row),
        .col_o (rc_col),
        .eol_o (rc_eol),
        .eof_o (rc_eof)
    );

    // Sweep FSM plus output-slot update; abort overrides everything outside IDLE.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pix_data_d  = pix_data_q;
        pix_valid_d = pix_valid_q;
        pix_row_d   = pix_row_q;
        pix_col_d   = pix_col_q;
        pix_eol_d   = pix_eol_q;
        pix_eof_d   = pix_eof_q;
        rc_clr      = 1'b0;

        if (load) begin
            pix_data_d  = mem_rd[7:0];
            pix_valid_d = 1'b1;
            pix_row_d   = rc_row;
            pix_col_d   = rc_col;
            pix_eol_d   = rc_eol;
            pix_eof_d   = rc_eof;
            idx_d       = idx_q + PIX_IDX_W'(1);
        end else if (handshake) begin
            pix_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StRun;
                    idx_d   = '0;
                    rc_clr  = 1'b1;
                end
            end
            StRun: begin
                if (load && (idx_q == LAST_IDX)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (handshake && pix_eof_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort && (state_q != StIdle)) begin
            state_d     = StIdle;
            pix_valid_d = 1'b0;
            idx_d       = '0;
            rc_clr      = 1'b1;
        end
    end

    // State, index and output-slot registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_row_q   <= '0;
            pix_col_q   <= '0;
            pix_eol_q   <= 1'b0;
            pix_eof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            pix_row_q   <= pix_row_d;
            pix_col_q   <= pix_col_d;
            pix_eol_q   <= pix_eol_d;
            pix_eof_q   <= pix_eof_d;
        end
    end

endmodule

// File: tb/tb_image_stream_reader.sv
// Scoreboard bench: four readers of different geometry share one byte memory model.
// Expected beats are queued when a frame is started; a negedge monitor pops and compares.
module tb_image_stream_reader;

    localparam int NDUT = 4;

    typedef struct packed {
        logic [1:0] tag;
        logic [7:0] data;
        logic [8:0] row;
        logic [8:0] col;
        logic       eol;
        logic       eof;
    } beat_t;

    int w_of    [NDUT] = '{390, 390, 4, 1};
    int h_of    [NDUT] = '{390, 3, 3, 5};
    int base_of [NDUT] = '{0, 0, 1000, 7};

    logic        clk = 1'b0;
    logic        rst;
    logic        start  [NDUT];
    logic        abort  [NDUT];
    logic        rdy    [NDUT];
    logic [31:0] rd     [NDUT];
    logic        busy   [NDUT];
    logic        done   [NDUT];
    logic        we     [NDUT];
    logic        pv     [NDUT];
    logic        eol    [NDUT];
    logic        eof    [NDUT];
    logic [31:0] addr   [NDUT];
    logic [7:0]  wd     [NDUT];
    logic [7:0]  pd     [NDUT];
    logic [8:0]  prow   [NDUT];
    logic [8:0]  pcol   [NDUT];

    logic [7:0]  mem [262144];
    beat_t       exp_q [$];
    int          beats    [NDUT];
    int          done_cnt [NDUT];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    // Combinational memory: pixel byte in [7:0], address-derived junk above it.
    always_comb begin
        for (int k = 0; k < NDUT; k++) begin
            rd[k] = (addr[k] < 32'd262144) ? {addr[k][23:0] ^ 24'h5a3c96, mem[addr[k][17:0]]}
                                           : 32'hffffff00;
        end
    end

    image_stream_reader u_dut_a (
        .CLK(clk), .RST(rst), .start(start[0]), .abort(abort[0]), .busy(busy[0]),
        .done(done[0]), .mem_addr(addr[0]), .mem_we(we[0]), .mem_wd(wd[0]), .mem_rd(rd[0]),
        .pix_data(pd[0]), .pix_valid(pv[0]), .pix_ready(rdy[0]), .pix_row(prow[0]),
        .pix_col(pcol[0]), .pix_eol(eol[0]), .pix_eof(eof[0])
    );

    image_stream_reader #(.IMG_W(390), .IMG_H(3)) u_dut_b (
        .CLK(clk), .RST(rst), .start(start[1]), .abort(abort[1]), .busy(busy[1]),
        .done(done[1]), .mem_addr(addr[1]), .mem_we(we[1]), .mem_wd(wd[1]), .mem_rd(rd[1]),
        .pix_data(pd[1]), .pix_valid(pv[1]), .pix_ready(rdy[1]), .pix_row(prow[1]),
        .pix_col(pcol[1]), .pix_eol(eol[1]), .pix_eof(eof[1])
    );

    image_stream_reader #(.IMG_W(4), .IMG_H(3), .BASE_ADDR(32'd1000)) u_dut_c (
        .CLK(clk), .RST(rst), .start(start[2]), .abort(abort[2]), .busy(busy[2]),
        .done(done[2]), .mem_addr(addr[2]), .mem_we(we[2]), .mem_wd(wd[2]), .mem_rd(rd[2]),
        .pix_data(pd[2]), .pix_valid(pv[2]), .pix_ready(rdy[2]), .pix_row(prow[2]),
        .pix_col(pcol[2]), .pix_eol(eol[2]), .pix_eof(eof[2])
    );

    image_stream_reader #(.IMG_W(1), .IMG_H(5), .BASE_ADDR(32'd7)) u_dut_d (
        .CLK(clk), .RST(rst), .start(start[3]), .abort(abort[3]), .busy(busy[3]),
        .done(done[3]), .mem_addr(addr[3]), .mem_we(we[3]), .mem_wd(wd[3]), .mem_rd(rd[3]),
        .pix_data(pd[3]), .pix_valid(pv[3]), .pix_ready(rdy[3]), .pix_row(prow[3]),
        .pix_col(pcol[3]), .pix_eol(eol[3]), .pix_eof(eof[3])
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: frame k yields pixels in raster order from its base address.
    task automatic push_frame(input int k);
        int n;
        beat_t b;
        n = w_of[k] * h_of[k];
        for (int i = 0; i < n; i++) begin
            b.tag  = 2'(k);
            b.data = mem[base_of[k] + i];
            b.row  = 9'(i / w_of[k]);
            b.col  = 9'(i % w_of[k]);
            b.eol  = ((i % w_of[k]) == w_of[k] - 1);
            b.eof  = (i == n - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic pulse_start(input int k);
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
    endtask

    task automatic wait_beats(input int k, input int target);
        int c;
        c = 0;
        while (beats[k] < target && c < 5000) begin
            tick();
            c++;
        end
        check("beat_wait", beats[k] >= target, 1'b1);
    endtask

    task automatic check_reset();
        for (int k = 0; k < NDUT; k++) begin
            check("reset_flags", {busy[k], done[k], pv[k], we[k], eol[k], eof[k], wd[k], pd[k],
                                  prow[k], pcol[k]}, '0);
            check("reset_addr", addr[k], base_of[k]);
        end
    endtask

    task automatic check_idle(input int k, input string name);
        check(name, {busy[k], pv[k], done[k]}, 3'b000);
    endtask

    // Random-ready frames; completion is detected through the done pulse count.
    task automatic run_random(input int k, input int frames);
        int d;
        int b;
        int c;
        for (int f = 0; f < frames; f++) begin
            push_frame(k);
            d = done_cnt[k];
            b = beats[k];
            rdy[k] = 1'($urandom_range(0, 1));
            pulse_start(k);
            c = 0;
            while (done_cnt[k] == d && c < 2000) begin
                rdy[k] = 1'($urandom_range(0, 1));
                tick();
                c++;
            end
            rdy[k] = 1'b0;
            repeat (3) tick();
            check("rand_done_once", done_cnt[k] - d, 1);
            check("rand_beats", beats[k] - b, w_of[k] * h_of[k]);
            check("rand_queue_empty", exp_q.size(), 0);
            check_idle(k, "rand_idle");
        end
    endtask

    // Monitor: scoreboard pops on handshakes, held outputs checked during stalls.
    initial begin
        beat_t       act;
        beat_t       e;
        beat_t       prev      [NDUT];
        logic [31:0] prev_addr [NDUT];
        logic        stall     [NDUT];
        logic        abt       [NDUT];
        for (int k = 0; k < NDUT; k++) begin
            stall[k]    = 1'b0;
            abt[k]      = 1'b0;
            beats[k]    = 0;
            done_cnt[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                act.tag  = 2'(k);
                act.data = pd[k];
                act.row  = prow[k];
                act.col  = pcol[k];
                act.eol  = eol[k];
                act.eof  = eof[k];
                if (rst) begin
                    stall[k] = 1'b0;
                end else begin
                    if (done[k]) done_cnt[k]++;
                    if (stall[k] && !abt[k]) begin
                        check("stall_hold", {pv[k], act, addr[k]},
                              {1'b1, prev[k], prev_addr[k]});
                    end
                    if (pv[k] && rdy[k]) begin
                        beats[k]++;
                        check("beat_expected", exp_q.size() != 0, 1'b1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("beat", act, e);
                        end
                    end
                    stall[k]     = pv[k] && !rdy[k];
                    abt[k]       = abort[k];
                    prev[k]      = act;
                    prev_addr[k] = addr[k];
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int d0;
        int cnt;
        logic seen;
        logic found;

        for (int k = 0; k < NDUT; k++) begin
            start[k] = 1'b0;
            abort[k] = 1'b0;
            rdy[k]   = 1'b0;
        end
        for (int i = 0; i < 262144; i++) mem[i] = 8'(i);

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset();

        // Abort at beat 50 of a full-size frame: back to idle, no done.
        rdy[0] = 1'b1;
        push_frame(0);
        b0 = beats[0];
        d0 = done_cnt[0];
        pulse_start(0);
        wait_beats(0, b0 + 50);
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        check_idle(0, "abort_idle");
        check("abort_addr", addr[0], 0);
        exp_q.delete();
        repeat (5) tick();
        check("abort_no_done", done_cnt[0], d0);
        check_idle(0, "abort_stays_idle");

        // Restart from pixel 0; stall on end of row 0.
        push_frame(0);
        b0 = beats[0];
        pulse_start(0);
        found = 1'b0;
        for (int c = 0; c < 1000 && !found; c++) begin
            if (pv[0] && pcol[0] == 9'd389) found = 1'b1;
            else tick();
        end
        check("find_px389", found, 1'b1);
        rdy[0] = 1'b0;
        check("stall_addr_start", addr[0], 390);
        repeat (5) begin
            tick();
            check("stall_px389", {pv[0], pd[0], prow[0], pcol[0], eol[0], eof[0], addr[0]},
                  {1'b1, 8'd133, 9'd0, 9'd389, 1'b1, 1'b0, 32'd390});
        end
        rdy[0] = 1'b1;
        wait_beats(0, b0 + 395);

        // Start mid-frame is ignored.
        pulse_start(0);
        check("mid_start_busy", busy[0], 1'b1);
        wait_beats(0, b0 + 500);

        // Start and abort together: abort wins.
        start[0] = 1'b1;
        abort[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        abort[0] = 1'b0;
        check_idle(0, "abort_beats_start");
        exp_q.delete();
        repeat (3) tick();
        check_idle(0, "abort_beats_start_hold");

        // Reset in the middle of a frame.
        push_frame(0);
        b0 = beats[0];
        pulse_start(0);
        wait_beats(0, b0 + 20);
        rdy[0] = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        check_reset();
        tick();
        check_idle(0, "post_reset_idle");

        // Two back-to-back full frames with ready high; start during DONE ignored.
        rdy[1] = 1'b1;
        for (int f = 0; f < 2; f++) begin
            push_frame(1);
            b0 = beats[1];
            d0 = done_cnt[1];
            pulse_start(1);
            cnt = 0;
            seen = 1'b0;
            while (!seen && cnt < 5000) begin
                @(posedge clk);
                cnt++;
                @(negedge clk);
                seen = done[1];
            end
            check("done_seen", seen, 1'b1);
            check("done_latency", cnt, 390 * 3 + 1);
            if (f == 0) start[1] = 1'b1;
            tick();
            start[1] = 1'b0;
            check_idle(1, "after_done_idle");
            repeat (2) tick();
            check_idle(1, "after_done_still_idle");
            check("frame_beats", beats[1] - b0, 390 * 3);
            check("frame_done_once", done_cnt[1] - d0, 1);
            check("frame_queue_empty", exp_q.size(), 0);
        end

        // Small geometries with random memory contents and random ready.
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        run_random(2, 3);
        run_random(3, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
